// File: rtl/majority_stream_voter.sv
// Streaming majority voter: Boyer-Moore candidate pass while collecting a frame, then a verification scan.
// Optional feature macro: MAJ_COUNT_OUT_EN adds the out_count port carrying the candidate match count.
module majority_stream_voter #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 13,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_found,
   output logic [WIDTH-1:0] out_value
`ifdef MAJ_COUNT_OUT_EN
   ,
   output logic [CW-1:0]    out_count
`endif
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {COLLECT, SCAN, RESULT} state_t;

   state_t           state;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [CW-1:0]    len;
   logic [CW-1:0]    cnt;
   logic [CW-1:0]    match;
   logic [CW-1:0]    rd;
   logic [WIDTH-1:0] cand;
   logic [WIDTH-1:0] rd_word;
   logic             accept;

   // Strict majority: 2*match > len, evaluated one bit wider so the doubling cannot wrap.
   function automatic logic is_majority(input logic [CW-1:0] m, input logic [CW-1:0] n);
      logic [CW:0] twice;
      twice = {m, 1'b0};
      return twice > {1'b0, n};
   endfunction

   assign in_ready = (state == COLLECT);
   assign accept   = in_valid & in_ready;
   assign rd_word  = mem[rd[AW-1:0]];

   // Frame storage carries no reset; only words below len are ever read back.
   always_ff @(posedge clk) begin
      if (accept) mem[len[AW-1:0]] <= in_data;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= COLLECT;
         len       <= '0;
         cnt       <= '0;
         cand      <= '0;
         match     <= '0;
         rd        <= '0;
         out_valid <= 1'b0;
         out_found <= 1'b0;
         out_value <= '0;
      end else begin
         case (state)
            // Collection: store the word and run the candidate vote on pre-beat cnt/cand.
            COLLECT: begin
               if (accept) begin
                  len <= len + CW'(1);
                  if (cnt == '0) begin
                     cand <= in_data;
                     cnt  <= CW'(1);
                  end else if (in_data == cand) begin
                     cnt <= cnt + CW'(1);
                  end else begin
                     cnt <= cnt - CW'(1);
                  end
                  if (in_last || (len == CW'(DEPTH - 1))) state <= SCAN;
               end
            end
            // Verification: count occurrences of the surviving candidate, one word per cycle.
            SCAN: begin
               if (rd_word == cand) match <= match + CW'(1);
               rd <= rd + CW'(1);
               if ((rd + CW'(1)) == len) state <= RESULT;
            end
            // Verdict: registered on the first RESULT cycle, held until the consumer takes it.
            RESULT: begin
               if (!out_valid) begin
                  out_valid <= 1'b1;
                  out_found <= is_majority(match, len);
                  out_value <= is_majority(match, len) ? cand : '0;
               end else if (out_ready) begin
                  state     <= COLLECT;
                  len       <= '0;
                  cnt       <= '0;
                  cand      <= '0;
                  match     <= '0;
                  rd        <= '0;
                  out_valid <= 1'b0;
                  out_found <= 1'b0;
                  out_value <= '0;
               end
            end
            default: state <= COLLECT;
         endcase
      end
   end

`ifdef MAJ_COUNT_OUT_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_count <= '0;
      end else if (state == RESULT) begin
         if (!out_valid)     out_count <= match;
         else if (out_ready) out_count <= '0;
      end
   end
`endif

endmodule

// File: tb/tb_majority_stream_voter.sv
// Scoreboard bench for majority_stream_voter: stimulus pushes expected verdicts, a monitor pops them on each output handshake.
module tb_majority_stream_voter;

   localparam int WIDTH = 4;
   localparam int DEPTH = 13;
   localparam int CW    = $clog2(DEPTH + 1);

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] in_data = '0;
   logic             in_last = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic             out_found;
   logic [WIDTH-1:0] out_value;
`ifdef MAJ_COUNT_OUT_EN
   logic [CW-1:0]    out_count;
`endif

   typedef struct {
      logic             found;
      logic [WIDTH-1:0] value;
      int               count;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_total = 0;
   int   n_pass  = 0;

   majority_stream_voter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_found (out_found),
      .out_value (out_value)
`ifdef MAJ_COUNT_OUT_EN
      ,
      .out_count (out_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, req);
   endtask

   task automatic push_exp(input logic f, input logic [WIDTH-1:0] v, input int c);
      exp_t e;
      e.found = f;
      e.value = v;
      e.count = c;
      exp_q.push_back(e);
   endtask

   // Presents one word and returns 1 time unit after the edge that accepted it.
   task automatic send_word(input logic [WIDTH-1:0] d, input logic last);
      logic rdy;
      bit   done;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      done     = 0;
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge clk);
         rdy = in_ready;
         @(posedge clk);
         if (rdy) done = 1;
      end
      #1;
      if (!done) chk("send_timeout", 0, 1);
   endtask

   task automatic idle_in();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // Called right after the last word's acceptance edge t: out_valid low after t+len, high after t+len+1.
   task automatic check_latency(input string name, input int len);
      repeat (len + 1) @(negedge clk);
      chk({name, "_early"}, out_valid, 0);
      @(negedge clk);
      chk(name, out_valid, 1);
   endtask

   task automatic send_frame(input logic [WIDTH-1:0] words[$]);
      for (int i = 0; i < words.size(); i++) send_word(words[i], i == words.size() - 1);
      idle_in();
   endtask

   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_result", 1, 0);
         end else begin
            mon_e = exp_q.pop_front();
            chk("out_found", out_found, mon_e.found);
            chk("out_value", out_value, mon_e.value);
`ifdef MAJ_COUNT_OUT_EN
            chk("out_count", out_count, mon_e.count);
`endif
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [WIDTH-1:0] f[$];
      bit seen;

      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_found", out_found, 0);
      chk("rst_out_value", out_value, 0);
`ifdef MAJ_COUNT_OUT_EN
      chk("rst_out_count", out_count, 0);
`endif
      @(posedge clk); #1;

      // Clear majority: 7 x A interleaved with 6 others.
      f = '{4'hA, 4'h1, 4'hA, 4'h2, 4'hA, 4'h3, 4'hA, 4'h4, 4'hA, 4'h5, 4'hA, 4'h6, 4'hA};
      push_exp(1'b1, 4'hA, 7);
      send_frame(f);
      check_latency("lat_clear", 13);

      // No majority: candidate ends on C with one match.
      f = '{4'h3, 4'h3, 4'h3, 4'h3, 4'h3, 4'h3, 4'h9, 4'h9, 4'h9, 4'h9, 4'h9, 4'h9, 4'hC};
      push_exp(1'b0, 4'h0, 1);
      send_frame(f);

      // Tie: candidate A survives with cnt 0, two matches of four.
      f = '{4'hA, 4'hA, 4'hB, 4'hB};
      push_exp(1'b0, 4'h0, 2);
      send_frame(f);

      // Single word frame.
      f = '{4'h5};
      push_exp(1'b1, 4'h5, 1);
      send_frame(f);
      check_latency("lat_single", 1);

      // Truncation with backpressure.
      @(posedge clk); #1;
      out_ready = 1'b0;
      push_exp(1'b1, 4'h7, 13);
      fork
         begin
            for (int i = 0; i < 13; i++) send_word(4'h7, 1'b0);
            chk("trunc_in_ready_low", in_ready, 0);
            send_word(4'h7, 1'b0);
            send_word(4'h7, 1'b0);
            push_exp(1'b1, 4'h7, 3);
            send_word(4'h7, 1'b1);
            idle_in();
         end
         begin
            seen = 0;
            for (int i = 0; i < 200 && !seen; i++) begin
               @(negedge clk);
               if (out_valid) seen = 1;
            end
            chk("bp_valid_seen", seen, 1);
            for (int i = 0; i < 5; i++) begin
               if (i > 0) @(negedge clk);
               chk("bp_hold_valid", out_valid, 1);
               chk("bp_hold_found", out_found, 1);
               chk("bp_hold_value", out_value, 4'h7);
`ifdef MAJ_COUNT_OUT_EN
               chk("bp_hold_count", out_count, 13);
`endif
            end
            @(posedge clk); #1;
            out_ready = 1'b1;
         end
      join
      check_latency("lat_trunc_next", 3);

      // Reset during SCAN discards the frame.
      f = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5};
      send_frame(f);
      @(negedge clk);
      @(negedge clk);
      @(posedge clk); #1 rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      chk("rst_mid_in_ready", in_ready, 1);
      chk("rst_mid_out_valid", out_valid, 0);
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (out_valid) seen = 1;
      end
      chk("rst_mid_no_valid", seen, 0);
      @(posedge clk); #1;

      f = '{4'h1, 4'h1, 4'h2};
      push_exp(1'b1, 4'h1, 2);
      send_frame(f);
      check_latency("lat_after_rst", 3);

      for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
      chk("scoreboard_drained", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
